// File: rtl/head_ptr_table.sv
// Bucket head-pointer table: one write port, RD_CHANNELS registered read ports, self-initialising sweep.
// Optional macro HEAD_TABLE_WR_BYPASS_EN forwards a same-cycle accepted write to matching reads.
module head_ptr_table #(
    parameter int unsigned BUCKET_WIDTH   = 8,
    parameter int unsigned HEAD_PTR_WIDTH = 10,
    parameter int unsigned RD_CHANNELS    = 2
) (
    input  logic                                 clk_i,
    input  logic                                 rst_n_i,
    input  logic                                 clear_i,
    output logic                                 init_done_o,
    input  logic                                 wr_en_i,
    output logic                                 wr_ready_o,
    input  logic [BUCKET_WIDTH-1:0]              wr_addr_i,
    input  logic [HEAD_PTR_WIDTH-1:0]            wr_data_ptr_i,
    input  logic                                 wr_data_ptr_val_i,
    input  logic [RD_CHANNELS-1:0]               rd_en_i,
    input  logic [RD_CHANNELS*BUCKET_WIDTH-1:0]  rd_addr_i,
    output logic [RD_CHANNELS-1:0]               rd_valid_o,
    output logic [RD_CHANNELS*HEAD_PTR_WIDTH-1:0] rd_data_ptr_o,
    output logic [RD_CHANNELS-1:0]               rd_data_ptr_val_o,
    output logic [BUCKET_WIDTH:0]                valid_cnt_o
);

    localparam int unsigned DEPTH = 2 ** BUCKET_WIDTH;
    localparam logic [BUCKET_WIDTH:0] CNT_ONE = (BUCKET_WIDTH + 1)'(1);

    typedef enum logic {ST_INIT, ST_RUN} state_e;

    state_e                    state_q, state_d;
    logic [BUCKET_WIDTH-1:0]   sweep_q;
    logic [HEAD_PTR_WIDTH-1:0] ptr_mem [DEPTH];
    logic [DEPTH-1:0]          val_q;

    logic                      wr_acc;
    logic                      mem_we;
    logic [BUCKET_WIDTH-1:0]   mem_waddr;
    logic [HEAD_PTR_WIDTH-1:0] mem_wptr;
    logic                      mem_wval;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) state_q <= ST_INIT;
        else          state_q <= state_d;
    end

    // The sweep and accepted writes share the single storage write port.
    always_comb begin
        state_d   = state_q;
        wr_acc    = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = sweep_q;
        mem_wptr  = '0;
        mem_wval  = 1'b0;
        case (state_q)
            ST_INIT: begin
                if (!clear_i) begin
                    mem_we = 1'b1;
                    if (sweep_q == '1) state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (clear_i) begin
                    state_d = ST_INIT;
                end else if (wr_en_i) begin
                    wr_acc    = 1'b1;
                    mem_we    = 1'b1;
                    mem_waddr = wr_addr_i;
                    mem_wptr  = wr_data_ptr_i;
                    mem_wval  = wr_data_ptr_val_i;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    assign init_done_o = (state_q == ST_RUN);
    assign wr_ready_o  = (state_q == ST_RUN);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i || clear_i)     sweep_q <= '0;
        else if (state_q == ST_INIT) sweep_q <= sweep_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_n_i && mem_we) ptr_mem[mem_waddr] <= mem_wptr;
    end

    always_ff @(posedge clk_i) begin
        if (rst_n_i && mem_we) val_q[mem_waddr] <= mem_wval;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i || clear_i || state_q == ST_INIT) begin
            valid_cnt_o <= '0;
        end else if (wr_acc) begin
            if (wr_data_ptr_val_i && !val_q[wr_addr_i])      valid_cnt_o <= valid_cnt_o + CNT_ONE;
            else if (!wr_data_ptr_val_i && val_q[wr_addr_i]) valid_cnt_o <= valid_cnt_o - CNT_ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            rd_valid_o        <= '0;
            rd_data_ptr_o     <= '0;
            rd_data_ptr_val_o <= '0;
        end else begin
            for (int unsigned k = 0; k < RD_CHANNELS; k++) begin
                rd_valid_o[k] <= rd_en_i[k] && (state_q == ST_RUN);
                if (rd_en_i[k] && (state_q == ST_RUN)) begin
`ifdef HEAD_TABLE_WR_BYPASS_EN
                    if (wr_acc && (wr_addr_i == rd_addr_i[k*BUCKET_WIDTH +: BUCKET_WIDTH])) begin
                        rd_data_ptr_o[k*HEAD_PTR_WIDTH +: HEAD_PTR_WIDTH] <= wr_data_ptr_i;
                        rd_data_ptr_val_o[k] <= wr_data_ptr_val_i;
                    end else begin
                        rd_data_ptr_o[k*HEAD_PTR_WIDTH +: HEAD_PTR_WIDTH] <=
                            ptr_mem[rd_addr_i[k*BUCKET_WIDTH +: BUCKET_WIDTH]];
                        rd_data_ptr_val_o[k] <= val_q[rd_addr_i[k*BUCKET_WIDTH +: BUCKET_WIDTH]];
                    end
`else
                    rd_data_ptr_o[k*HEAD_PTR_WIDTH +: HEAD_PTR_WIDTH] <=
                        ptr_mem[rd_addr_i[k*BUCKET_WIDTH +: BUCKET_WIDTH]];
                    rd_data_ptr_val_o[k] <= val_q[rd_addr_i[k*BUCKET_WIDTH +: BUCKET_WIDTH]];
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_head_ptr_table.sv
// Directed bench for head_ptr_table with BUCKET_WIDTH=4: vector table plus init/clear/reset sequences.
module tb_head_ptr_table;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        init_done;
    logic        wr_en = 1'b0;
    logic        wr_ready;
    logic [3:0]  wr_addr = '0;
    logic [9:0]  wr_ptr = '0;
    logic        wr_val = 1'b0;
    logic [1:0]  rd_en = '0;
    logic [7:0]  rd_addr = '0;
    logic [1:0]  rd_valid;
    logic [19:0] rd_ptr;
    logic [1:0]  rd_val;
    logic [4:0]  valid_cnt;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    head_ptr_table #(
        .BUCKET_WIDTH  (4),
        .HEAD_PTR_WIDTH(10),
        .RD_CHANNELS   (2)
    ) dut (
        .clk_i            (clk),
        .rst_n_i          (rst_n),
        .clear_i          (clear),
        .init_done_o      (init_done),
        .wr_en_i          (wr_en),
        .wr_ready_o       (wr_ready),
        .wr_addr_i        (wr_addr),
        .wr_data_ptr_i    (wr_ptr),
        .wr_data_ptr_val_i(wr_val),
        .rd_en_i          (rd_en),
        .rd_addr_i        (rd_addr),
        .rd_valid_o       (rd_valid),
        .rd_data_ptr_o    (rd_ptr),
        .rd_data_ptr_val_o(rd_val),
        .valid_cnt_o      (valid_cnt)
    );

    typedef struct {
        logic       wr_en;
        logic [3:0] wa;
        logic [9:0] wp;
        logic       wv;
        logic [1:0] re;
        logic [3:0] ra0;
        logic [3:0] ra1;
        logic [1:0] ev;
        logic [9:0] ep0;
        logic       ev0;
        logic [9:0] ep1;
        logic       ev1;
        logic [4:0] ecnt;
    } vec_t;

    vec_t vecs [10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Ticks until init_done rises (bounded); reads must never be answered meanwhile.
    task automatic wait_init(input string name);
        int n = 0;
        while (!init_done && n < 40) begin
            tick();
            n++;
            check({name, "_rdvalid_in_init"}, 32'(rd_valid), 32'd0);
        end
        check(name, n, 32'd16);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_init_done", 32'(init_done), 0);
        check("rst_wr_ready", 32'(wr_ready), 0);
        check("rst_rd_valid", 32'(rd_valid), 0);
        check("rst_rd_ptr", 32'(rd_ptr), 0);
        check("rst_rd_val", 32'(rd_val), 0);
        check("rst_cnt", 32'(valid_cnt), 0);

        rst_n = 1'b1;
        wait_init("init_len");
        check("run_wr_ready", 32'(wr_ready), 1);
        check("run_cnt0", 32'(valid_cnt), 0);

        // Every bucket reads invalid after the sweep
        for (int b = 0; b < 16; b++) begin
            rd_en = 2'b11;
            rd_addr = {4'(15 - b), 4'(b)};
            tick();
            check("sweep_rd_valid", 32'(rd_valid), 32'h3);
            check("sweep_rd_ptr", 32'(rd_ptr), 0);
            check("sweep_rd_val", 32'(rd_val), 0);
        end

        vecs[0] = '{1'b1, 4'd3, 10'h02A, 1'b1, 2'b00, 4'd0, 4'd0, 2'b00, 10'h000, 1'b0, 10'h000, 1'b0, 5'd1};
        vecs[1] = '{1'b0, 4'd0, 10'h000, 1'b0, 2'b10, 4'd0, 4'd3, 2'b10, 10'h000, 1'b0, 10'h02A, 1'b1, 5'd1};
        vecs[2] = '{1'b1, 4'd5, 10'h155, 1'b1, 2'b11, 4'd3, 4'd4, 2'b11, 10'h02A, 1'b1, 10'h000, 1'b0, 5'd2};
        vecs[3] = '{1'b1, 4'd3, 10'h011, 1'b1, 2'b11, 4'd5, 4'd0, 2'b11, 10'h155, 1'b1, 10'h000, 1'b0, 5'd2};
        vecs[4] = '{1'b1, 4'd5, 10'h155, 1'b0, 2'b11, 4'd3, 4'd3, 2'b11, 10'h011, 1'b1, 10'h011, 1'b1, 5'd1};
        vecs[5] = '{1'b0, 4'd0, 10'h000, 1'b0, 2'b11, 4'd5, 4'd2, 2'b11, 10'h155, 1'b0, 10'h000, 1'b0, 5'd1};
        vecs[6] = '{1'b1, 4'd5, 10'h000, 1'b0, 2'b00, 4'd0, 4'd0, 2'b00, 10'h000, 1'b0, 10'h000, 1'b0, 5'd1};
        vecs[7] = '{1'b1, 4'd9, 10'h3FF, 1'b1, 2'b01, 4'd5, 4'd0, 2'b01, 10'h000, 1'b0, 10'h000, 1'b0, 5'd2};
        vecs[8] = '{1'b1, 4'd9, 10'h200, 1'b1, 2'b10, 4'd0, 4'd3, 2'b10, 10'h000, 1'b0, 10'h011, 1'b1, 5'd2};
        vecs[9] = '{1'b0, 4'd0, 10'h000, 1'b0, 2'b11, 4'd9, 4'd9, 2'b11, 10'h200, 1'b1, 10'h200, 1'b1, 5'd2};

        for (int i = 0; i < 10; i++) begin
            wr_en = vecs[i].wr_en;
            wr_addr = vecs[i].wa;
            wr_ptr = vecs[i].wp;
            wr_val = vecs[i].wv;
            rd_en = vecs[i].re;
            rd_addr = {vecs[i].ra1, vecs[i].ra0};
            tick();
            check($sformatf("v%0d_rd_valid", i), 32'(rd_valid), 32'(vecs[i].ev));
            check($sformatf("v%0d_cnt", i), 32'(valid_cnt), 32'(vecs[i].ecnt));
            if (vecs[i].ev[0]) begin
                check($sformatf("v%0d_ptr0", i), 32'(rd_ptr[9:0]), 32'(vecs[i].ep0));
                check($sformatf("v%0d_val0", i), 32'(rd_val[0]), 32'(vecs[i].ev0));
            end
            if (vecs[i].ev[1]) begin
                check($sformatf("v%0d_ptr1", i), 32'(rd_ptr[19:10]), 32'(vecs[i].ep1));
                check($sformatf("v%0d_val1", i), 32'(rd_val[1]), 32'(vecs[i].ev1));
            end
        end

        // Same-cycle write and read of bucket 7
        wr_en = 1'b1; wr_addr = 4'd7; wr_ptr = 10'h3FF; wr_val = 1'b1;
        rd_en = 2'b01; rd_addr = {4'd0, 4'd7};
        tick();
        wr_en = 1'b0;
`ifdef HEAD_TABLE_WR_BYPASS_EN
        check("same_cycle_ptr", 32'(rd_ptr[9:0]), 32'h3FF);
        check("same_cycle_val", 32'(rd_val[0]), 1);
`else
        check("same_cycle_ptr", 32'(rd_ptr[9:0]), 0);
        check("same_cycle_val", 32'(rd_val[0]), 0);
`endif
        check("same_cycle_cnt", 32'(valid_cnt), 3);
        rd_en = 2'b00;
        tick();
        check("hold_rd_valid", 32'(rd_valid), 0);
        rd_en = 2'b01;
        tick();
        check("after_ptr", 32'(rd_ptr[9:0]), 32'h3FF);
        check("after_val", 32'(rd_val[0]), 1);

        // Clear with a same-cycle write: write dropped, full resweep
        clear = 1'b1; wr_en = 1'b1; wr_addr = 4'd2; wr_ptr = 10'h077; wr_val = 1'b1;
        rd_en = 2'b11; rd_addr = {4'd3, 4'd2};
        tick();
        clear = 1'b0; wr_en = 1'b0;
        check("clr_wr_ready", 32'(wr_ready), 0);
        check("clr_init_done", 32'(init_done), 0);
        check("clr_cnt", 32'(valid_cnt), 0);
        wait_init("clr_len");
        check("clr_cnt_run", 32'(valid_cnt), 0);
        tick();
        check("clr_rd_valid", 32'(rd_valid), 32'h3);
        check("clr_b2_val", 32'(rd_val[0]), 0);
        check("clr_b2_ptr", 32'(rd_ptr[9:0]), 0);
        check("clr_b3_val", 32'(rd_val[1]), 0);

        // Reset in the middle of a sweep restarts it
        rd_en = 2'b00;
        wr_en = 1'b1; wr_addr = 4'd1; wr_ptr = 10'h0AB; wr_val = 1'b1;
        tick();
        wr_en = 1'b0;
        check("b1_cnt", 32'(valid_cnt), 1);
        rd_en = 2'b01; rd_addr = {4'd0, 4'd1};
        tick();
        rd_en = 2'b00;
        check("b1_ptr", 32'(rd_ptr[9:0]), 32'h0AB);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        repeat (8) tick();
        check("mid_init_done", 32'(init_done), 0);
        rst_n = 1'b0;
        tick();
        check("mid_rst_ptr", 32'(rd_ptr), 0);
        check("mid_rst_cnt", 32'(valid_cnt), 0);
        check("mid_rst_wr_ready", 32'(wr_ready), 0);
        rst_n = 1'b1;
        wait_init("mid_rst_len");
        rd_en = 2'b01; rd_addr = {4'd0, 4'd1};
        tick();
        check("mid_b1_valid", 32'(rd_valid), 1);
        check("mid_b1_val", 32'(rd_val[0]), 0);
        check("mid_b1_ptr", 32'(rd_ptr[9:0]), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
